// File: rtl/addr_decode_pkg.sv
// Shared types, default channel map and field helper for the chip-select decoder.
// Field values are the 16 address bits A[AW-1:AW-16]; the map gives RAM, ROM and six IO windows.
package addr_decode_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        ERR   = 2'd3
    } state_t;

    // Channel 0 sits in the least significant field; IO channels 2..7 decode 0x5..0xA.
    localparam logic [127:0] DEF_CH_BASE = {16'hA000, 16'h9000, 16'h8000, 16'h7000,
                                            16'h6000, 16'h5000, 16'h4000, 16'h0000};
    localparam logic [127:0] DEF_CH_MASK = {16'hF000, 16'hF000, 16'hF000, 16'hF000,
                                            16'hF000, 16'hF000, 16'hF000, 16'hC000};
    localparam logic [31:0]  DEF_CH_WS   = 32'h4F71_0532;
    localparam int           DEF_ROM_CH  = 1;
    localparam int           DEF_RAM_CH  = 0;

    function automatic logic [15:0] chan_field(input logic [255:0] vec, input logic [3:0] idx);
        return vec[{idx, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/addr_decode_ws_counter.sv
// Loadable down-counter that holds at zero and flags the last wait cycle.
module ws_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          term
);

    logic [CW-1:0] cnt_r;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign term = (cnt_r == {{(CW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/addr_decode_ws.sv
// Bus address decoder: one-hot chip selects, per-channel wait states, decode timeout
// and a boot overlay that maps low memory onto the ROM channel until ROM is addressed.
module addr_decode_ws
    import addr_decode_pkg::*;
#(
    parameter int                 AW      = 24,
    parameter int                 NCH     = 8,
    parameter int                 WSW     = 4,
    parameter int                 TOUT    = 63,
    parameter logic [NCH*16-1:0]  CH_BASE = DEF_CH_BASE,
    parameter logic [NCH*16-1:0]  CH_MASK = DEF_CH_MASK,
    parameter logic [NCH*WSW-1:0] CH_WS   = DEF_CH_WS,
    parameter int                 ROM_CH  = DEF_ROM_CH,
    parameter int                 RAM_CH  = DEF_RAM_CH
) (
    input  logic           CLK,
    input  logic           RES,
    input  logic [AW-9:0]  A,
    input  logic           nWE,
    input  logic           BACT,
    input  logic           OVLSET,
    output logic [NCH-1:0] CS,
    output logic           RDY,
    output logic           BERR,
    output logic           Overlay,
    output logic           WRCS
);

    localparam int CW = (WSW > 8) ? WSW : 8;

    state_t         state_r;
    logic [NCH-1:0] cs_r;
    logic           rdy_r;
    logic           berr_r;
    logic           wrcs_r;
    logic           ovl_r;
    logic           hit_r;
    logic           bact_r;
    logic           armed_r;

    logic [15:0]    a_top_s;
    logic [NCH-1:0] match_nov_s;
    logic [NCH-1:0] match_s;
    logic [NCH-1:0] onehot_s;
    logic [3:0]     hit_idx_s;
    logic           hit_s;
    logic [WSW-1:0] ws_s;
    logic           start_s;
    logic           load_s;
    logic [CW-1:0]  load_val_s;
    logic           dec_s;
    logic           term_s;

    // Address decode with overlay override and lowest-index priority.
    always_comb begin
        a_top_s = A[AW-9 -: 16];
        for (int i = 0; i < NCH; i++) begin
            match_nov_s[i] = ((a_top_s & chan_field(256'(CH_MASK), 4'(i)))
                              == chan_field(256'(CH_BASE), 4'(i)));
        end
        match_s = match_nov_s;
        if (ovl_r) begin
            match_s[RAM_CH] = 1'b0;
            match_s[ROM_CH] = match_s[ROM_CH] | (a_top_s[15:12] == 4'h0);
        end else begin
            match_s = match_nov_s;
        end
        hit_idx_s = 4'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            hit_idx_s = match_s[i] ? 4'(i) : hit_idx_s;
        end
        hit_s = |match_s;
        ws_s  = '0;
        for (int i = 0; i < NCH; i++) begin
            onehot_s[i] = hit_s && (hit_idx_s == 4'(i));
            ws_s        = (hit_idx_s == 4'(i)) ? CH_WS[i*WSW +: WSW] : ws_s;
        end
    end

    // A start needs BACT to have been seen low since reset, not just a cleared bact_r.
    always_comb begin
        start_s    = BACT && !bact_r && armed_r;
        load_s     = (state_r == IDLE) && start_s;
        load_val_s = hit_s ? CW'(ws_s) : CW'(TOUT);
        dec_s      = (state_r == WAIT) && BACT;
    end

    ws_counter #(
        .CW(CW)
    ) u_ws_counter (
        .clk      (CLK),
        .rst      (RES),
        .load     (load_s),
        .load_val (load_val_s),
        .dec      (dec_s),
        .term     (term_s)
    );

    // Cycle FSM with its registered outputs, overlay flag and BACT history.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_r <= IDLE;
            cs_r    <= '0;
            rdy_r   <= 1'b0;
            berr_r  <= 1'b0;
            wrcs_r  <= 1'b0;
            ovl_r   <= 1'b1;
            hit_r   <= 1'b0;
            bact_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            bact_r  <= BACT;
            armed_r <= armed_r | !BACT;
            if (OVLSET) begin
                ovl_r <= 1'b1;
            end else if (load_s && match_nov_s[ROM_CH]) begin
                ovl_r <= 1'b0;
            end else begin
                ovl_r <= ovl_r;
            end
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        cs_r   <= onehot_s;
                        wrcs_r <= !nWE && hit_s;
                        hit_r  <= hit_s;
                        if (hit_s && (ws_s == '0)) begin
                            state_r <= READY;
                            rdy_r   <= 1'b1;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (!BACT) begin
                        state_r <= IDLE;
                        cs_r    <= '0;
                        wrcs_r  <= 1'b0;
                    end else if (term_s) begin
                        state_r <= hit_r ? READY : ERR;
                        rdy_r   <= hit_r;
                        berr_r  <= !hit_r;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                READY, ERR: begin
                    if (!BACT) begin
                        state_r <= IDLE;
                        cs_r    <= '0;
                        wrcs_r  <= 1'b0;
                        rdy_r   <= 1'b0;
                        berr_r  <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cs_r    <= '0;
                    wrcs_r  <= 1'b0;
                    rdy_r   <= 1'b0;
                    berr_r  <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (AW > 24) begin : g_low_bits
            logic unused_low_s;
            assign unused_low_s = ^A[AW-25:0];
        end
    endgenerate

    assign CS      = cs_r;
    assign RDY     = rdy_r;
    assign BERR    = berr_r;
    assign Overlay = ovl_r;
    assign WRCS    = wrcs_r;

endmodule

// File: tb/tb_addr_decode_ws.sv
// Directed and randomized bus cycles checked against an address-range model of the decoder.
module tb_addr_decode_ws;

    localparam int TOUT_T = 63;

    logic        CLK;
    logic        RES;
    logic [15:0] A;
    logic        nWE;
    logic        BACT;
    logic        OVLSET;
    logic [7:0]  CS;
    logic        RDY;
    logic        BERR;
    logic        Overlay;
    logic        WRCS;

    int checks = 0;
    int errors = 0;
    bit ovl_m  = 1'b1;
    int ws_tab [8] = '{2, 3, 5, 0, 1, 7, 15, 4};

    addr_decode_ws #(
        .AW      (24),
        .NCH     (8),
        .WSW     (4),
        .TOUT    (TOUT_T),
        .CH_BASE ({16'hA000, 16'h9000, 16'h8000, 16'h7000, 16'h6000, 16'h5000, 16'h4000, 16'h0000}),
        .CH_MASK ({16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hC000}),
        .CH_WS   (32'h4F71_0532),
        .ROM_CH  (1),
        .RAM_CH  (0)
    ) dut (
        .CLK     (CLK),
        .RES     (RES),
        .A       (A),
        .nWE     (nWE),
        .BACT    (BACT),
        .OVLSET  (OVLSET),
        .CS      (CS),
        .RDY     (RDY),
        .BERR    (BERR),
        .Overlay (Overlay),
        .WRCS    (WRCS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory map in 1 MB regions: RAM 0x0-0x3, ROM 0x4, IO 0x5-0xA, rest unmapped.
    function automatic int model_ch(input logic [23:0] addr, input bit ovl);
        int region;
        region = int'(addr >> 20);
        if (ovl && region == 0) return 1;
        if (region < 4) return ovl ? -1 : 0;
        if (region == 4) return 1;
        if (region >= 5 && region <= 10) return region - 3;
        return -1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One bus cycle; abort_at>0 drops BACT after that many sampled edges.
    task automatic do_cycle(input logic [23:0] addr, input bit wr, input bit pulse_set, input int abort_at);
        int ch;
        int lat;
        bit seen;
        logic [7:0] exp_cs;
        ch     = model_ch(addr, ovl_m);
        exp_cs = (ch < 0) ? 8'h00 : (8'h01 << ch);
        lat    = (ch < 0) ? TOUT_T + 1 : ws_tab[ch] + 1;
        A      = addr[23:8];
        nWE    = !wr;
        BACT   = 1'b1;
        OVLSET = pulse_set;
        tick();
        OVLSET = 1'b0;
        if (pulse_set) ovl_m = 1'b1;
        else if (addr[23:20] == 4'h4) ovl_m = 1'b0;
        check("cs_at_start", 32'(CS), 32'(exp_cs));
        if (ch >= 0) check("wrcs_at_start", 32'(WRCS), 32'(wr));
        check("overlay_after_start", 32'(Overlay), 32'(ovl_m));
        A   = 16'($urandom);
        nWE = 1'($urandom);
        seen = 1'b0;
        if (abort_at > 0) begin
            for (int k = 1; k < abort_at; k++) begin
                seen = seen | RDY | BERR;
                tick();
            end
            BACT = 1'b0;
            tick();
            check("abort_cs_cleared", 32'(CS), 32'h0);
            for (int k = 0; k < lat + 2; k++) begin
                seen = seen | RDY | BERR;
                tick();
            end
            check("abort_no_rdy_berr", 32'(seen), 32'h0);
        end else begin
            for (int n = 1; n < lat; n++) begin
                seen = seen | RDY | BERR;
                tick();
            end
            check("no_early_term", 32'(seen), 32'h0);
            check("rdy_latency", 32'(RDY), 32'(ch >= 0));
            check("berr_latency", 32'(BERR), 32'(ch < 0));
            A = 16'($urandom);
            repeat (3) tick();
            check("term_held", 32'({RDY, BERR}), 32'({ch >= 0, ch < 0}));
            check("cs_held", 32'(CS), 32'(exp_cs));
            BACT = 1'b0;
            tick();
            check("end_cs_cleared", 32'(CS), 32'h0);
            check("end_term_cleared", 32'({RDY, BERR}), 32'h0);
        end
        tick();
    endtask

    initial begin
        bit seen;
        int lat;
        logic [23:0] raddr;
        RES = 1'b1; A = 16'h0; nWE = 1'b1; BACT = 1'b0; OVLSET = 1'b0;
        repeat (3) tick();
        check("rst_cs", 32'(CS), 32'h0);
        check("rst_rdy_berr", 32'({RDY, BERR}), 32'h0);
        check("rst_wrcs", 32'(WRCS), 32'h0);
        check("rst_overlay", 32'(Overlay), 32'h1);
        RES = 1'b0;
        tick();

        // Overlay boot read, overlay clear via ROM, then RAM visible at low addresses.
        do_cycle(24'h000100, 1'b0, 1'b0, 0);
        do_cycle(24'h400000, 1'b0, 1'b0, 0);
        do_cycle(24'h000100, 1'b0, 1'b0, 0);
        do_cycle(24'h600000, 1'b1, 1'b0, 0);
        do_cycle(24'hA12300, 1'b1, 1'b0, 0);
        do_cycle(24'hC00000, 1'b0, 1'b0, 0);
        do_cycle(24'h500000, 1'b0, 1'b0, 1);
        do_cycle(24'h500000, 1'b1, 1'b0, 0);
        do_cycle(24'h400000, 1'b0, 1'b1, 0);
        do_cycle(24'h000100, 1'b0, 1'b0, 0);
        do_cycle(24'h400000, 1'b0, 1'b0, 0);

        OVLSET = 1'b1;
        tick();
        OVLSET = 1'b0;
        ovl_m  = 1'b1;
        check("ovlset_pulse", 32'(Overlay), 32'h1);
        do_cycle(24'h200000, 1'b0, 1'b0, 0);

        // Reset while waiting with BACT held high.
        do_cycle(24'h400000, 1'b0, 1'b0, 0);
        A = 16'h5000; nWE = 1'b0; BACT = 1'b1;
        repeat (2) tick();
        RES = 1'b1;
        tick();
        check("midrst_cs", 32'(CS), 32'h0);
        check("midrst_outs", 32'({RDY, BERR, WRCS}), 32'h0);
        check("midrst_overlay", 32'(Overlay), 32'h1);
        RES   = 1'b0;
        ovl_m = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | (CS != 8'h00) | RDY | BERR;
        end
        check("no_start_after_rst", 32'(seen), 32'h0);
        BACT = 1'b0;
        tick();
        do_cycle(24'h500000, 1'b0, 1'b0, 0);

        for (int r = 0; r < 40; r++) begin
            raddr = 24'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                OVLSET = 1'b1;
                tick();
                OVLSET = 1'b0;
                ovl_m  = 1'b1;
                check("rand_ovlset", 32'(Overlay), 32'h1);
            end
            lat = (model_ch(raddr, ovl_m) < 0) ? TOUT_T + 1 : ws_tab[model_ch(raddr, ovl_m)] + 1;
            if (lat > 2 && $urandom_range(0, 5) == 0)
                do_cycle(raddr, 1'($urandom), 1'b0, int'($urandom_range(1, lat - 1)));
            else
                do_cycle(raddr, 1'($urandom), 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
